// File: rtl/psg_bus_master.sv
// ---------------------------------------------------------------------------
// psg_bus_master
//
// Queues register read/write commands and plays each one out on an
// AY-3-8910 style PSG bus (BDIR/BC2/BC1 + A8 + 8-bit data). A small command
// FIFO decouples the pushing client from the slow, clock-enable driven bus
// sequencer. Every command runs four equal-length phases:
//   ADDR (latch address) -> GAP1 -> DATA (write strobe / read) -> GAP2
// and is followed by at least one IDLE clken tick.
//
// Optional feature macro: PSG_BUS_MASTER_READBACK_EN
//   defined   : read commands strobe DATA with 3'b011 and return psg_do.
//   undefined : read commands leave the bus inactive in DATA and return
//               8'hFF with the same response timing; psg_do is ignored.
//
// Parameters
//   FIFO_DEPTH : command FIFO entries (power of two, 2..16)
//   PHASE_LEN  : clken ticks per bus phase (1..15)
//
// Ports
//   clock          system clock, rising edge
//   reset          synchronous, active-low
//   clken          PSG clock enable; bus sequencer advances only when high
//   cmd_valid/cmd_ready/cmd_rd/cmd_reg/cmd_data
//                  command push handshake (cmd_rd: 1=read, 0=write)
//   rsp_valid      one-clock pulse carrying a read result
//   rsp_data       last read result, held between pulses
//   busy           FIFO non-empty or sequencer not idle
//   a8,bdir,bc2,bc1,psg_di
//                  PSG bus control and data towards the PSG
//   psg_do         data driven by the PSG
// ---------------------------------------------------------------------------
module psg_bus_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int PHASE_LEN  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clken,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rd,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       a8,
  output logic       bdir,
  output logic       bc2,
  output logic       bc1,
  output logic [7:0] psg_di,
  input  logic [7:0] psg_do
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0]  LAST_TICK = 4'(PHASE_LEN - 1);

  // Bus codes {bdir,bc2,bc1}
  localparam logic [2:0] BUS_INACT = 3'b010;
  localparam logic [2:0] BUS_ADDR  = 3'b111;
  localparam logic [2:0] BUS_WRITE = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_GAP1,
    S_DATA,
    S_GAP2
  } state_t;

  // -------------------------------------------------------------------------
  // Read data path selection
  // -------------------------------------------------------------------------
  logic [2:0] w_rd_code;
  logic [7:0] w_rd_val;

`ifdef PSG_BUS_MASTER_READBACK_EN
  assign w_rd_code = 3'b011;
  assign w_rd_val  = psg_do;
`else
  // Readback disabled: DATA stays inactive and the response is all-ones.
  logic w_unused_psg_do;
  assign w_rd_code       = BUS_INACT;
  assign w_rd_val        = 8'hFF;
  assign w_unused_psg_do = ^psg_do;
`endif

  // -------------------------------------------------------------------------
  // Command FIFO
  // -------------------------------------------------------------------------
  logic [16:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [16:0]   w_head;

  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign w_push    = cmd_valid & ~w_full;
  assign w_head    = r_mem[r_rd_ptr];
  assign cmd_ready = ~w_full;

  // Storage carries no reset; validity is tracked by the pointers/count.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_rd, cmd_reg, cmd_data};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Bus sequencer: state register
  // -------------------------------------------------------------------------
  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_tick;
  logic [3:0] w_tick_nxt;
  logic       w_phase_end;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_tick  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Bus sequencer: next state
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_pop       = 1'b0;
    w_phase_end = 1'b0;
    if (clken) begin
      if (r_state == S_IDLE) begin
        // The popping tick is itself an IDLE tick, which guarantees the
        // mandatory idle gap between consecutive commands.
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_ADDR;
          w_tick_nxt  = '0;
        end
      end else if (r_tick == LAST_TICK) begin
        w_phase_end = 1'b1;
        w_tick_nxt  = '0;
        case (r_state)
          S_ADDR:  w_state_nxt = S_GAP1;
          S_GAP1:  w_state_nxt = S_DATA;
          S_DATA:  w_state_nxt = S_GAP2;
          default: w_state_nxt = S_IDLE;
        endcase
      end else begin
        w_tick_nxt = r_tick + 4'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Holding register for the command currently on the bus
  // -------------------------------------------------------------------------
  logic       r_hold_rd;
  logic [7:0] r_hold_reg;
  logic [7:0] r_hold_data;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_hold_rd   <= 1'b0;
      r_hold_reg  <= '0;
      r_hold_data <= '0;
    end else if (w_pop) begin
      {r_hold_rd, r_hold_reg, r_hold_data} <= w_head;
    end
  end

  // -------------------------------------------------------------------------
  // Read response: capture on the last DATA tick, pulse on the next clock
  // -------------------------------------------------------------------------
  logic       w_sample;
  logic       r_rsp_valid;
  logic [7:0] r_rsp_data;

  assign w_sample = (r_state == S_DATA) & w_phase_end & r_hold_rd;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 8'hFF;
    end else begin
      r_rsp_valid <= w_sample;
      if (w_sample) begin
        r_rsp_data <= w_rd_val;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign busy      = ~w_empty | (r_state != S_IDLE);

  // -------------------------------------------------------------------------
  // Bus output decode
  // -------------------------------------------------------------------------
  logic [2:0] w_bus;

  always_comb begin
    w_bus  = BUS_INACT;
    a8     = 1'b0;
    psg_di = 8'hFF;
    case (r_state)
      S_ADDR: begin
        w_bus  = BUS_ADDR;
        a8     = 1'b1;
        psg_di = r_hold_reg;
      end
      S_GAP1: begin
        psg_di = r_hold_reg;
      end
      S_DATA: begin
        a8 = 1'b1;
        if (r_hold_rd) begin
          w_bus = w_rd_code;
        end else begin
          w_bus  = BUS_WRITE;
          psg_di = r_hold_data;
        end
      end
      S_GAP2: begin
        // Keep write data stable through the hold gap after the strobe.
        if (!r_hold_rd) begin
          psg_di = r_hold_data;
        end
      end
      default: begin
      end
    endcase
  end

  assign {bdir, bc2, bc1} = w_bus;

endmodule

// File: tb/tb_psg_bus_master.sv
// ---------------------------------------------------------------------------
// tb_psg_bus_master
//
// Scoreboard bench for psg_bus_master (FIFO_DEPTH=4, PHASE_LEN=2).
// Stimulus pushes each command into cmd_q (and the expected read result into
// rsp_q). A bus monitor replays the expected four-phase bus pattern for the
// command at the head of cmd_q, and a response monitor checks every
// rsp_valid pulse against rsp_q. A tiny PSG model returns register contents
// for the address latched during ADDR.
// ---------------------------------------------------------------------------
module tb_psg_bus_master;

  localparam int FIFO_DEPTH = 4;
  localparam int PHASE_LEN  = 2;

`ifdef PSG_BUS_MASTER_READBACK_EN
  localparam logic [2:0] RD_CODE = 3'b011;
`else
  localparam logic [2:0] RD_CODE = 3'b010;
`endif

  logic       clock;
  logic       reset;
  logic       clken;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rd;
  logic [7:0] cmd_reg;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       a8;
  logic       bdir;
  logic       bc2;
  logic       bc1;
  logic [7:0] psg_di;
  logic [7:0] psg_do;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [16:0] cmd_q[$];
  logic [7:0]  rsp_q[$];
  bit          mon_en  = 1'b0;
  bit          sparse  = 1'b0;
  int          mode    = 1;   // 0: clken off, 1: continuous, 2: 1-in-16
  int          clk_cnt = 0;
  logic [7:0]  last_rsp;

  psg_bus_master #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .PHASE_LEN  (PHASE_LEN)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .clken     (clken),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rd    (cmd_rd),
    .cmd_reg   (cmd_reg),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .a8        (a8),
    .bdir      (bdir),
    .bc2       (bc2),
    .bc1       (bc1),
    .psg_di    (psg_di),
    .psg_do    (psg_do)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // PSG model: fixed register contents, address latched during ADDR.
  logic [7:0] psg_regs [16];
  logic [7:0] lat_addr = 8'h00;

  initial begin
    for (int i = 0; i < 16; i++) psg_regs[i] = 8'(8'h30 + i);
    psg_regs[13] = 8'h0A;
  end

  always @(posedge clock) begin
    if (bdir && bc2 && bc1) lat_addr <= psg_di;
  end

  assign psg_do = (!bdir && bc2 && bc1) ? psg_regs[lat_addr[3:0]] : 8'h5A;

  // clken generator, updated just after each rising edge.
  initial begin
    clken = 1'b1;
    forever begin
      @(posedge clock);
      #2;
      clk_cnt++;
      case (mode)
        0:       clken = 1'b0;
        1:       clken = 1'b1;
        default: clken = ((clk_cnt % 16) == 0);
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_rd(input logic [7:0] r);
`ifdef PSG_BUS_MASTER_READBACK_EN
    return psg_regs[r[3:0]];
`else
    return 8'hFF;
`endif
  endfunction

  // Expected {a8, bdir, bc2, bc1, psg_di, rsp_valid} for a phase of command c.
  function automatic logic [12:0] exp_bus(input int ph, input logic [16:0] c, input bit first);
    logic       rd;
    logic [7:0] r;
    logic [7:0] d;
    rd = c[16];
    r  = c[15:8];
    d  = c[7:0];
    case (ph)
      1:       return {1'b1, 3'b111, r, 1'b0};
      2:       return {1'b0, 3'b010, r, 1'b0};
      3:       return rd ? {1'b1, RD_CODE, 8'hFF, 1'b0} : {1'b1, 3'b110, d, 1'b0};
      4:       return {1'b0, 3'b010, (rd ? 8'hFF : d), (rd & first)};
      default: return {1'b0, 3'b010, 8'hFF, 1'b0};
    endcase
  endfunction

  // Bus monitor
  initial begin : bus_mon
    logic [16:0] cur;
    logic [12:0] got;
    int          ph;
    int          ticks;
    int          clks;
    bit          first;
    cur = '0; ph = 0; ticks = 0; clks = 0; first = 1'b0;
    wait (mon_en);
    forever begin
      @(negedge clock);
      got = {a8, bdir, bc2, bc1, psg_di, rsp_valid};
      if (ph == 0 && {bdir, bc2, bc1} == 3'b111) begin
        if (cmd_q.size() == 0) begin
          check("unexpected_cmd", 32'd1, 32'd0);
        end else begin
          cur = cmd_q.pop_front();
          ph = 1; ticks = 0; clks = 0; first = 1'b1;
        end
      end
      check((ph == 0) ? "bus_idle" : "bus_cmd", 32'(got), 32'(exp_bus(ph, cur, first)));
      first = 1'b0;
      clks++;
      if (ph != 0 && clken) begin
        if (ticks == PHASE_LEN - 1) begin
          if (sparse) check("phase_clocks", clks, PHASE_LEN * 16);
          ph++; ticks = 0; clks = 0; first = 1'b1;
          if (ph == 5) ph = 0;
        end else begin
          ticks++;
        end
      end
      if (!reset) ph = 0;
    end
  end

  // Response monitor
  initial begin : rsp_mon
    wait (mon_en);
    forever begin
      @(negedge clock);
      if (rsp_valid === 1'b1) begin
        if (rsp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
        else                   check("rsp_data", 32'(rsp_data), 32'(rsp_q.pop_front()));
      end
    end
  end

  task automatic push(input logic rd, input logic [7:0] r, input logic [7:0] d);
    int n;
    n = 0;
    while (!cmd_ready && n < 500) begin
      @(posedge clock); #1;
      n++;
    end
    check("push_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_rd    = rd;
    cmd_reg   = r;
    cmd_data  = d;
    cmd_q.push_back({rd, r, d});
    if (rd) begin
      rsp_q.push_back(exp_rd(r));
      last_rsp = exp_rd(r);
    end
    @(posedge clock); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin : stim
    int n;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_rd    = 1'b0;
    cmd_reg   = 8'h00;
    cmd_data  = 8'h00;
    last_rsp  = 8'hFF;
    repeat (3) @(posedge clock);
    #1;

    // Reset state
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'hFF);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_a8", 32'(a8), 32'd0);
    check("rst_bus", 32'({bdir, bc2, bc1}), 32'b010);
    check("rst_psg_di", 32'(psg_di), 32'hFF);
    reset  = 1'b1;
    mon_en = 1'b1;
    @(posedge clock); #1;

    // Single write, continuous clken
    push(1'b0, 8'd7, 8'h38);
    wait_idle(100);
    check("busy_after_write", 32'(busy), 32'd0);

    // Reads
    push(1'b1, 8'd13, 8'h00);
    wait_idle(100);
    repeat (3) @(posedge clock);
    #1;
    check("rsp_hold_13", 32'(rsp_data), 32'(last_rsp));
    push(1'b1, 8'd8, 8'h00);
    wait_idle(100);
    check("rsp_hold_8", 32'(rsp_data), 32'(last_rsp));

    // Fill the FIFO while the sequencer cannot advance
    mode = 0;
    push(1'b0, 8'd1, 8'h11);
    push(1'b1, 8'd2, 8'h00);
    push(1'b0, 8'd3, 8'h33);
    push(1'b1, 8'd4, 8'h00);
    check("full_cmd_ready", 32'(cmd_ready), 32'd0);
    check("full_busy", 32'(busy), 32'd1);
    mode = 1;
    push(1'b0, 8'd5, 8'h55);
    wait_idle(500);

    // Sparse clken: every phase stretches to PHASE_LEN*16 clocks
    sparse = 1'b1;
    mode   = 2;
    push(1'b0, 8'd2, 8'hC3);
    wait_idle(2000);
    sparse = 1'b0;
    mode   = 1;
    @(posedge clock); #1;

    // Reset during DATA of a read, with a second command queued
    push(1'b1, 8'd13, 8'h00);
    push(1'b0, 8'd9, 8'h99);
    n = 0;
    while (!(a8 === 1'b1 && bdir === 1'b0) && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("reach_data", 32'(a8 && !bdir), 32'd1);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    check("abort_bus", 32'({bdir, bc2, bc1}), 32'b010);
    check("abort_a8", 32'(a8), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_rsp_data", 32'(rsp_data), 32'hFF);
    check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_q.delete();
    rsp_q.delete();
    reset = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    check("flushed_busy", 32'(busy), 32'd0);

    // Normal operation after reset
    push(1'b0, 8'd0, 8'hA5);
    push(1'b1, 8'd3, 8'h00);
    wait_idle(200);
    repeat (3) @(posedge clock);
    #1;

    check("cmd_q_empty", 32'(cmd_q.size()), 32'd0);
    check("rsp_q_empty", 32'(rsp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
